// File: rtl/mdu_iter_if.sv
// Handshake and writeback bundle between the CPU decode/regfile side and the
// iterative multiply/divide unit.
interface mdu_iter_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  rd;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] wd;
  logic [4:0]  wn;
  logic        we;

  modport master (
    output start, op, a, b, rd,
    input  stall, busy, done, wd, wn, we
  );

  modport slave (
    input  start, op, a, b, rd,
    output stall, busy, done, wd, wn, we
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative 32-bit multiply/divide unit: 32 shift-add or restoring-divide steps,
// then a one-cycle register file write. Divider present only with MDU_DIV_EN.
module mdu_iter (
  input  logic      clk,
  input  logic      clrn,
  mdu_iter_if.slave m
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t      state, state_d;
  logic [4:0]  cnt;
  logic [31:0] opnd;     // multiplicand (a) or divisor (b)
  logic [63:0] acc;      // {hi, lo} product, or {remainder, quotient}
  logic [63:0] step;
  logic [32:0] sum;
  logic [31:0] res;
  logic        sel_hi;
  logic [4:0]  rd_r;
  logic [31:0] wd_r;
  logic [4:0]  wn_r;
  logic        we_r;
`ifdef MDU_DIV_EN
  logic        is_div;
  logic [32:0] trial;
`endif

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would race with the datapath block.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else       state <= state_d;
  end

  // NOTE: every always_comb output gets a default first, otherwise a path that
  // leaves it unassigned infers a latch.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (m.start) begin
`ifdef MDU_DIV_EN
          state_d = RUN;
`else
          state_d = m.op[1] ? DONE : RUN;
`endif
        end
      end
      RUN:     if (cnt == 5'd31) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m.stall = ((state == IDLE) && m.start) || (state == RUN);
    m.busy  = (state == RUN) || (state == DONE);
    m.done  = (state == DONE);
  end

  // One iteration. The divide reuses acc as {rem[31:0], quo}: the 33-bit
  // partial remainder after the left shift is acc[63:31].
  always_comb begin
    sum  = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opnd : 32'd0)};
    step = {sum, acc[31:1]};
`ifdef MDU_DIV_EN
    trial = acc[63:31] - {1'b0, opnd};
    if (is_div)
      step = trial[32] ? {acc[62:0], 1'b0} : {trial[31:0], acc[30:0], 1'b1};
`endif
    res = sel_hi ? step[63:32] : step[31:0];
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt    <= '0;
      opnd   <= '0;
      acc    <= '0;
      sel_hi <= 1'b0;
      rd_r   <= '0;
      wd_r   <= '0;
      wn_r   <= '0;
      we_r   <= 1'b0;
`ifdef MDU_DIV_EN
      is_div <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (m.start) begin
            cnt    <= '0;
            sel_hi <= m.op[0];
            rd_r   <= m.rd;
`ifdef MDU_DIV_EN
            is_div <= m.op[1];
            opnd   <= m.op[1] ? m.b : m.a;
            acc    <= {32'd0, (m.op[1] ? m.a : m.b)};
`else
            opnd   <= m.a;
            acc    <= {32'd0, m.b};
            if (m.op[1]) begin
              wd_r <= 32'd0;
              wn_r <= m.rd;
              we_r <= (m.rd != 5'd0);
            end
`endif
          end
        end
        RUN: begin
          acc <= step;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            wd_r <= res;
            wn_r <= rd_r;
            we_r <= (rd_r != 5'd0);
          end
        end
        DONE:    we_r <= 1'b0;
        default: we_r <= 1'b0;
      endcase
    end
  end

  assign m.wd = wd_r;
  assign m.wn = wn_r;
  assign m.we = we_r;

endmodule
